// File: rtl/irq_request_unit_if.sv
// rtl/irq_request_unit_if.sv - button/request bus between board stimulus and irq_request_unit
interface irq_request_unit_if #(
    parameter int N_LINES = 4
);
    logic [N_LINES-1:0] btn;
    logic [N_LINES-1:0] en;
    logic [N_LINES-1:0] ack;
    logic [N_LINES-1:0] irq;
    logic [N_LINES-1:0] overrun;
    logic [7:0]         evt_cnt;

    modport master (
        output btn, en, ack,
        input  irq, overrun, evt_cnt
    );

    modport slave (
        input  btn, en, ack,
        output irq, overrun, evt_cnt
    );
endinterface

// File: rtl/irq_request_unit.sv
// rtl/irq_request_unit.sv - synchronize, debounce and latch push-button interrupt requests
module irq_request_unit #(
    parameter int N_LINES    = 4,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic                 clk,
    input  logic                 in_RST,
    irq_request_unit_if.slave    bus
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {STABLE0, STABLE1} deb_state_t;

    logic [N_LINES-1:0] sync1;
    logic [N_LINES-1:0] sync2;
    logic [N_LINES-1:0] level;
    logic [N_LINES-1:0] level_q;
    logic [N_LINES-1:0] acc;
    logic [N_LINES-1:0] irq_q;
    logic [N_LINES-1:0] overrun_q;
    logic [7:0]         evt_q;
    logic [8:0]         n_acc;
    logic [8:0]         evt_sum;

    always_ff @(posedge clk) begin
        if (in_RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < N_LINES; g++) begin : g_line
        deb_state_t       state_q;
        deb_state_t       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_ff @(posedge clk) begin
            if (in_RST) begin
                state_q <= STABLE0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Any sample that agrees with the debounced level restarts the count.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            if (sync2[g] != (state_q == STABLE1)) begin
                if (cnt_q == DEB_LAST) begin
                    state_d = sync2[g] ? STABLE1 : STABLE0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        assign level[g] = (state_q == STABLE1);
    end

    assign acc = level & ~level_q & bus.en;

    always_comb begin
        n_acc = '0;
        for (int i = 0; i < N_LINES; i++) begin
            n_acc = n_acc + 9'(acc[i]);
        end
        evt_sum = {1'b0, evt_q} + n_acc;
    end

    // A fresh event wins over a simultaneous ack, so it is never lost.
    always_ff @(posedge clk) begin
        if (in_RST) begin
            level_q   <= '0;
            irq_q     <= '0;
            overrun_q <= '0;
            evt_q     <= '0;
        end else begin
            level_q   <= level;
            irq_q     <= acc | (irq_q & ~bus.ack);
            overrun_q <= overrun_q | (acc & irq_q & ~bus.ack);
            evt_q     <= evt_sum[8] ? 8'hFF : evt_sum[7:0];
        end
    end

    assign bus.irq     = irq_q;
    assign bus.overrun = overrun_q;
    assign bus.evt_cnt = evt_q;
endmodule

// File: tb/tb_irq_request_unit.sv
// tb/tb_irq_request_unit.sv - scoreboard bench for irq_request_unit
module tb_irq_request_unit;
    localparam int N   = 4;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    irq_request_unit_if #(.N_LINES(N)) bus ();

    irq_request_unit #(.N_LINES(N), .DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .clk    (clk),
        .in_RST (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] irq;
        logic [N-1:0] ovr;
        logic [7:0]   cnt;
    } exp_t;

    exp_t         expq[$];
    logic [N-1:0] hist[$];
    logic [N-1:0] m_d, m_dprev, m_irq, m_ovr, m_acc, m_nd;
    int           m_cnt;
    bit           flip;

    // Debounced level flips once the last DEB synchronized samples all disagree with it;
    // the synchronized sample seen at an edge is the raw button two edges earlier.
    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            for (int j = 0; j < DEB + 2; j++) hist.push_back('0);
            m_d = '0; m_dprev = '0; m_irq = '0; m_ovr = '0; m_cnt = 0;
        end else begin
            m_acc = m_d & ~m_dprev & bus.en;
            for (int i = 0; i < N; i++) begin
                if (m_acc[i] && m_irq[i] && !bus.ack[i]) m_ovr[i] = 1'b1;
                if (m_acc[i]) m_irq[i] = 1'b1;
                else if (bus.ack[i]) m_irq[i] = 1'b0;
            end
            m_cnt = m_cnt + $countones(m_acc);
            if (m_cnt > 255) m_cnt = 255;
            for (int i = 0; i < N; i++) begin
                flip = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (hist[hist.size() - 2 - j][i] == m_d[i]) flip = 1'b0;
                m_nd[i] = flip ? ~m_d[i] : m_d[i];
            end
            m_dprev = m_d;
            m_d     = m_nd;
            hist.push_back(bus.btn);
            void'(hist.pop_front());
        end
        expq.push_back('{irq: m_irq, ovr: m_ovr, cnt: 8'(m_cnt)});
    end

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (bus.irq !== e.irq || bus.overrun !== e.ovr || bus.evt_cnt !== e.cnt) begin
                errors++;
                if (errors < 20)
                    $display("FAIL outputs t=%0t irq=%b want %b overrun=%b want %b evt_cnt=%0d want %0d",
                             $time, bus.irq, e.irq, bus.overrun, e.ovr, bus.evt_cnt, e.cnt);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    int hold[N];

    initial begin
        rst = 1'b1; bus.btn = '1; bus.en = '1; bus.ack = '0;
        cyc(3);
        check("reset_irq", int'(bus.irq), 0);
        check("reset_evt", int'(bus.evt_cnt), 0);
        rst = 1'b0;
        cyc(DEB + 6);
        check("held_irq", int'(bus.irq), 15);
        check("held_evt", int'(bus.evt_cnt), 4);
        bus.ack = '1; cyc(1); bus.ack = '0; bus.btn = '0;
        cyc(DEB + 6);
        check("cleared_irq", int'(bus.irq), 0);

        bus.btn = 4'b0001; cyc(3); bus.btn = '0; cyc(DEB + 6);
        check("glitch_irq", int'(bus.irq[0]), 0);
        check("glitch_evt", int'(bus.evt_cnt), 4);
        bus.btn = 4'b0001; cyc(6 + DEB);
        check("press_irq", int'(bus.irq[0]), 1);
        bus.ack = 4'b0001; cyc(1); bus.ack = '0;
        check("ack_clear", int'(bus.irq[0]), 0);
        cyc(20);
        check("held_no_rearm", int'(bus.irq[0]), 0);
        check("held_evt5", int'(bus.evt_cnt), 5);
        bus.btn = '0; cyc(DEB + 4); bus.btn = 4'b0001; cyc(DEB + 6);
        check("repress_irq", int'(bus.irq[0]), 1);
        bus.ack = 4'b0001; cyc(1); bus.ack = '0; bus.btn = '0; cyc(DEB + 4);

        bus.btn = 4'b0010; cyc(DEB + 4); bus.btn = '0; cyc(DEB + 4);
        bus.btn = 4'b0010; cyc(DEB + 6);
        check("overrun_irq", int'(bus.irq[1]), 1);
        check("overrun_flag", int'(bus.overrun[1]), 1);
        bus.btn = '0; bus.ack = 4'b0010; cyc(1); bus.ack = '0; cyc(DEB + 4);
        bus.btn = 4'b0010; cyc(DEB + 2); bus.ack = 4'b0010; cyc(1); bus.ack = '0;
        check("ack_collide_irq", int'(bus.irq[1]), 1);
        check("ack_collide_ovr", int'(bus.overrun[1]), 1);
        bus.btn = '0; bus.ack = 4'b0010; cyc(1); bus.ack = '0; cyc(DEB + 4);

        bus.en = 4'b0111; bus.btn = 4'b1000; cyc(DEB + 6);
        check("mask_irq", int'(bus.irq[3]), 0);
        bus.en = '1; cyc(4);
        check("mask_no_replay", int'(bus.irq[3]), 0);
        check("mask_evt", int'(bus.evt_cnt), 9);
        bus.btn = '0; cyc(DEB + 4);

        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 10);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    bus.btn[i] = ~bus.btn[i];
                    hold[i] = $urandom_range(1, 10);
                end
                bus.ack[i] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 19) == 0) bus.en = N'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst = 1'b0; bus.ack = '0; bus.en = '1; bus.btn = '0;
        cyc(DEB + 4);

        for (int p = 0; p < 80; p++) begin
            bus.btn = '1; cyc(DEB + 4);
            bus.btn = '0; cyc(DEB + 4);
        end
        check("sat_evt", int'(bus.evt_cnt), 255);
        bus.btn = '1; cyc(DEB + 6);
        check("sat_hold", int'(bus.evt_cnt), 255);
        check("sat_overrun", int'(bus.overrun), 15);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
